// File: rtl/mpu_sensor_scanner_if.sv
// SPI byte-engine port bundle shared by the MPU9250 scanner (master) and the engine (slave).
interface mpu_sensor_scanner_if;
  logic [6:0] spi_address;
  logic [7:0] spi_wr_data;
  logic       spi_rd_wr_sel;
  logic       spi_start;
  logic       spi_busy;
  logic [7:0] spi_rd_data;

  // Handshake: spi_start is a one-cycle request, raised only while spi_busy=0 with address/data/sel
  // stable; the engine may raise spi_busy from the next cycle, and spi_rd_data is valid once it falls.
  modport master (
    output spi_address, spi_wr_data, spi_rd_wr_sel, spi_start,
    input  spi_busy, spi_rd_data
  );

  modport slave (
    input  spi_address, spi_wr_data, spi_rd_wr_sel, spi_start,
    output spi_busy, spi_rd_data
  );
endinterface

// File: rtl/mpu_sensor_scanner.sv
// MPU9250 register scanner: wake, configure, then loop reading NUM_CH big-endian 16-bit channels.
// Optional WHO_AM_I check enabled by defining MPU_SCAN_WHOAMI_CHECK_EN.
module mpu_sensor_scanner #(
  parameter int unsigned NUM_CH      = 3,
  parameter logic [6:0]  START_ADDR  = 7'h3B,
  parameter int unsigned IDLE_CYCLES = 10,
  parameter logic [7:0]  EXPECT_ID   = 8'h71
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mpu_sensor_scanner_if.master    spi,
  output logic [16*NUM_CH-1:0]    sample_data,
  output logic                    sample_valid,
  output logic                    arm_read_enable,
  output logic [15:0]             frame_count,
  output logic [7:0]              whoami,
  output logic                    init_done,
  output logic                    id_error,
  output logic [4:0]              dbg_state
);

  typedef enum logic [2:0] {
    ST_BOOT, ST_PWR, ST_ID, ST_CFG, ST_SCAN, ST_COMMIT, ST_IDLE, ST_ERR
  } state_e;

  typedef enum logic [1:0] {PH_XFER, PH_GUARD, PH_WAIT, PH_DONE} phase_e;

  localparam logic [3:0]  LAST_B    = 4'(2*NUM_CH-1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [3:0]          byte_q, byte_d;
  logic [7:0]          hold_q, hold_d;
  logic [16*NUM_CH-1:0] shadow_q, shadow_d;
  logic [16*NUM_CH-1:0] sample_data_q, sample_data_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [15:0]         idle_cnt_q, idle_cnt_d;
  logic                init_done_q, init_done_d;
  logic                xfer_done;

`ifdef MPU_SCAN_WHOAMI_CHECK_EN
  logic [7:0] whoami_q, whoami_d;
  logic       id_error_q, id_error_d;
`endif

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    byte_d          = byte_q;
    hold_d          = hold_q;
    shadow_d        = shadow_q;
    sample_data_d   = sample_data_q;
    frame_count_d   = frame_count_q;
    idle_cnt_d      = idle_cnt_q;
    init_done_d     = init_done_q;
`ifdef MPU_SCAN_WHOAMI_CHECK_EN
    whoami_d        = whoami_q;
    id_error_d      = id_error_q;
`endif
    spi.spi_address   = 7'h00;
    spi.spi_wr_data   = 8'h00;
    spi.spi_rd_wr_sel = 1'b1;
    spi.spi_start     = 1'b0;
    sample_valid      = 1'b0;
    arm_read_enable   = 1'b0;
    xfer_done         = 1'b0;

    case (state_q)
      ST_PWR:  begin spi.spi_address = 7'h6B; spi.spi_rd_wr_sel = 1'b0; end
      ST_ID:   spi.spi_address = 7'h75;
      ST_CFG:  begin spi.spi_address = 7'h37; spi.spi_wr_data = 8'h02; spi.spi_rd_wr_sel = 1'b0; end
      ST_SCAN: spi.spi_address = START_ADDR + {3'b000, byte_q};
      default: ;
    endcase

    // One byte transaction, shared by every bus-accessing state: XFER -> GUARD -> WAIT -> DONE.
    if (state_q inside {ST_PWR, ST_ID, ST_CFG, ST_SCAN}) begin
      case (phase_q)
        PH_XFER:  if (!spi.spi_busy) begin spi.spi_start = 1'b1; phase_d = PH_GUARD; end
        PH_GUARD: phase_d = PH_WAIT;
        PH_WAIT:  if (!spi.spi_busy) phase_d = PH_DONE;
        default:  begin phase_d = PH_XFER; xfer_done = 1'b1; end
      endcase
    end

    case (state_q)
      ST_BOOT: if (!spi.spi_busy) state_d = ST_PWR;
`ifdef MPU_SCAN_WHOAMI_CHECK_EN
      ST_PWR:  if (xfer_done) state_d = ST_ID;
      ST_ID: begin
        if (xfer_done) begin
          whoami_d = spi.spi_rd_data;
          if (spi.spi_rd_data == EXPECT_ID) state_d = ST_CFG;
          else begin
            id_error_d = 1'b1;
            state_d    = ST_ERR;
          end
        end
      end
`else
      ST_PWR:  if (xfer_done) state_d = ST_CFG;
`endif
      ST_CFG: begin
        if (xfer_done) begin
          init_done_d = 1'b1;
          byte_d      = 4'd0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (xfer_done) begin
          if (!byte_q[0]) hold_d = spi.spi_rd_data;
          else begin
            for (int k = 0; k < NUM_CH; k++)
              if (byte_q[3:1] == 3'(k)) shadow_d[16*k +: 16] = {hold_q, spi.spi_rd_data};
          end
          // Publish on the edge into COMMIT so data and count are already stable while sample_valid is high.
          if (byte_q == LAST_B) begin
            sample_data_d = shadow_d;
            frame_count_d = frame_count_q + 16'd1;
            byte_d        = 4'd0;
            state_d       = ST_COMMIT;
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end
      end
      ST_COMMIT: begin
        sample_valid    = 1'b1;
        arm_read_enable = 1'b1;
        idle_cnt_d      = 16'd0;
        state_d         = (IDLE_CYCLES == 0) ? ST_SCAN : ST_IDLE;
      end
      ST_IDLE: begin
        arm_read_enable = 1'b1;
        if (idle_cnt_q == IDLE_LAST) state_d = ST_SCAN;
        else idle_cnt_d = idle_cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      phase_q       <= PH_XFER;
      byte_q        <= 4'd0;
      hold_q        <= 8'h00;
      shadow_q      <= '0;
      sample_data_q <= '0;
      frame_count_q <= 16'h0000;
      idle_cnt_q    <= 16'h0000;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      byte_q        <= byte_d;
      hold_q        <= hold_d;
      shadow_q      <= shadow_d;
      sample_data_q <= sample_data_d;
      frame_count_q <= frame_count_d;
      idle_cnt_q    <= idle_cnt_d;
      init_done_q   <= init_done_d;
    end
  end

`ifdef MPU_SCAN_WHOAMI_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      whoami_q   <= 8'h00;
      id_error_q <= 1'b0;
    end else begin
      whoami_q   <= whoami_d;
      id_error_q <= id_error_d;
    end
  end

  assign whoami   = whoami_q;
  assign id_error = id_error_q;
`else
  // EXPECT_ID has no role without the identity check; keep it referenced.
  logic [7:0] unused_expect_id;
  assign unused_expect_id = EXPECT_ID;
  assign whoami           = 8'h00;
  assign id_error         = 1'b0;
`endif

  assign sample_data = sample_data_q;
  assign frame_count = frame_count_q;
  assign init_done   = init_done_q;
  assign dbg_state   = {state_q, phase_q};

endmodule

// File: tb/tb_mpu_sensor_scanner.sv
// Directed bench for mpu_sensor_scanner: default instance (NUM_CH=3) and a 7-channel, zero-idle instance.
module tb_mpu_sensor_scanner;

  localparam int BUSY_CYC = 4;
`ifdef MPU_SCAN_WHOAMI_CHECK_EN
  localparam int CFG_IDX = 2;
`else
  localparam int CFG_IDX = 1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n  = 1'b0;
  logic rst7_n = 1'b0;

  // ---------------- default instance ----------------
  mpu_sensor_scanner_if bus();
  logic [47:0] sd_a;
  logic        sv_a, arm_a, init_a, iderr_a;
  logic [15:0] fc_a;
  logic [7:0]  who_a;
  logic [4:0]  dbg_a;

  mpu_sensor_scanner dut (
    .clk(clk), .reset_n(rst_n), .spi(bus),
    .sample_data(sd_a), .sample_valid(sv_a), .arm_read_enable(arm_a),
    .frame_count(fc_a), .whoami(who_a), .init_done(init_a), .id_error(iderr_a),
    .dbg_state(dbg_a)
  );

  // ---------------- 7-channel instance ----------------
  mpu_sensor_scanner_if bus7();
  logic [111:0] sd_7;
  logic         sv_7, arm_7, init_7, iderr_7;
  logic [15:0]  fc_7;
  logic [7:0]   who_7;
  logic [4:0]   dbg_7;

  mpu_sensor_scanner #(.NUM_CH(7), .IDLE_CYCLES(0)) dut7 (
    .clk(clk), .reset_n(rst7_n), .spi(bus7),
    .sample_data(sd_7), .sample_valid(sv_7), .arm_read_enable(arm_7),
    .frame_count(fc_7), .whoami(who_7), .init_done(init_7), .id_error(iderr_7),
    .dbg_state(dbg_7)
  );

  // ---------------- engine models ----------------
  logic [7:0]  mem_a [128];
  logic [7:0]  mem_7 [128];
  logic        busy_a = 1'b0, busy_7 = 1'b0;
  logic [7:0]  rd_a = 8'h00, rd_7 = 8'h00;
  logic [6:0]  addr_a = 7'h00, addr_7 = 7'h00;
  logic        sel_a = 1'b0, sel_7 = 1'b0;
  int          cnt_a = 0, cnt_7 = 0;
  int          start_busy_a = 0, start_busy_7 = 0;
  logic [15:0] log_a[$];
  logic [15:0] log_7[$];

  assign bus.spi_busy     = busy_a;
  assign bus.spi_rd_data  = rd_a;
  assign bus7.spi_busy    = busy_7;
  assign bus7.spi_rd_data = rd_7;

  always @(posedge clk) begin
    if (bus.spi_start && busy_a) start_busy_a <= start_busy_a + 1;
    if (bus.spi_start) begin
      log_a.push_back({bus.spi_rd_wr_sel, bus.spi_address, bus.spi_wr_data});
      addr_a <= bus.spi_address;
      sel_a  <= bus.spi_rd_wr_sel;
      busy_a <= 1'b1;
      cnt_a  <= BUSY_CYC - 1;
    end else if (busy_a) begin
      if (cnt_a != 0) cnt_a <= cnt_a - 1;
      else begin
        busy_a <= 1'b0;
        if (sel_a) rd_a <= mem_a[addr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (bus7.spi_start && busy_7) start_busy_7 <= start_busy_7 + 1;
    if (bus7.spi_start) begin
      log_7.push_back({bus7.spi_rd_wr_sel, bus7.spi_address, bus7.spi_wr_data});
      addr_7 <= bus7.spi_address;
      sel_7  <= bus7.spi_rd_wr_sel;
      busy_7 <= 1'b1;
      cnt_7  <= BUSY_CYC - 1;
    end else if (busy_7) begin
      if (cnt_7 != 0) cnt_7 <= cnt_7 - 1;
      else begin
        busy_7 <= 1'b0;
        if (sel_7) rd_7 <= mem_7[addr_7];
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 8'h00;
      mem_7[i] = 8'(i);
    end
    mem_a[7'h3B] = 8'h12; mem_a[7'h3C] = 8'h34; mem_a[7'h3D] = 8'h56;
    mem_a[7'h3E] = 8'h78; mem_a[7'h3F] = 8'h9A; mem_a[7'h40] = 8'hBC;
    mem_a[7'h75] = 8'h71;
    mem_7[7'h75] = 8'h71;
  end

`ifdef MPU_SCAN_WHOAMI_CHECK_EN
  // Instance whose sensor reports the wrong identity.
  mpu_sensor_scanner_if busb();
  logic [47:0] sd_b;
  logic        sv_b, arm_b, init_b, iderr_b;
  logic [15:0] fc_b;
  logic [7:0]  who_b;
  logic [4:0]  dbg_b;
  logic        busy_b = 1'b0;
  logic [7:0]  rd_b = 8'h00;
  logic        sel_b = 1'b0;
  int          cnt_b = 0, starts_b = 0, valid_b = 0, arm_b_cnt = 0;

  mpu_sensor_scanner dutb (
    .clk(clk), .reset_n(rst7_n), .spi(busb),
    .sample_data(sd_b), .sample_valid(sv_b), .arm_read_enable(arm_b),
    .frame_count(fc_b), .whoami(who_b), .init_done(init_b), .id_error(iderr_b),
    .dbg_state(dbg_b)
  );

  assign busb.spi_busy    = busy_b;
  assign busb.spi_rd_data = rd_b;

  always @(posedge clk) begin
    if (busb.spi_start) begin
      starts_b <= starts_b + 1;
      sel_b    <= busb.spi_rd_wr_sel;
      busy_b   <= 1'b1;
      cnt_b    <= BUSY_CYC - 1;
    end else if (busy_b) begin
      if (cnt_b != 0) cnt_b <= cnt_b - 1;
      else begin
        busy_b <= 1'b0;
        if (sel_b) rd_b <= 8'h70;
      end
    end
  end

  always @(negedge clk) begin
    if (sv_b) valid_b <= valid_b + 1;
    if (arm_b) arm_b_cnt <= arm_b_cnt + 1;
  end
`endif

  // ---------------- 7-channel monitor ----------------
  logic [111:0] data7 = '0;
  bit           got7 = 1'b0;
  int           arm7_run = 0, arm7_pulses = 0, arm7_bad = 0, valid7 = 0;

  always @(negedge clk) begin
    if (sv_7) begin
      valid7 <= valid7 + 1;
      if (!got7) begin
        data7 <= sd_7;
        got7  <= 1'b1;
      end
    end
    if (arm_7) arm7_run <= arm7_run + 1;
    else if (arm7_run != 0) begin
      arm7_pulses <= arm7_pulses + 1;
      if (arm7_run != 1) arm7_bad <= arm7_bad + 1;
      arm7_run <= 0;
    end
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_valid_a(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sv_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_init_a(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (init_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_starts_a(input int n, input int max_cyc, output bit ok);
    int seen;
    seen = 0;
    ok   = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.spi_start) seen++;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " sample_data"}, 128'(sd_a), 128'h0);
    check_eq({tag, " sample_valid"}, 128'(sv_a), 128'h0);
    check_eq({tag, " arm_read_enable"}, 128'(arm_a), 128'h0);
    check_eq({tag, " frame_count"}, 128'(fc_a), 128'h0);
    check_eq({tag, " init_done"}, 128'(init_a), 128'h0);
    check_eq({tag, " spi_start"}, 128'(bus.spi_start), 128'h0);
    check_eq({tag, " spi_address"}, 128'(bus.spi_address), 128'h0);
    check_eq({tag, " spi_wr_data"}, 128'(bus.spi_wr_data), 128'h0);
    check_eq({tag, " spi_rd_wr_sel"}, 128'(bus.spi_rd_wr_sel), 128'h1);
    check_eq({tag, " whoami"}, 128'(who_a), 128'h0);
    check_eq({tag, " id_error"}, 128'(iderr_a), 128'h0);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] scan_exp [6];
  logic [47:0] frame_exp;
  int          cyc0;
  bit          ok;

  initial begin
    scan_exp  = '{16'hBB00, 16'hBC00, 16'hBD00, 16'hBE00, 16'hBF00, 16'hC000};
    frame_exp = {16'h9ABC, 16'h5678, 16'h1234};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset dbg_state", 128'(dbg_a), 128'h0);
    check_eq("reset dut7 dbg_state", 128'(dbg_7), 128'h0);
    rst_n  = 1'b1;
    rst7_n = 1'b1;

    // Power-up and configuration writes.
    wait_init_a(200, ok);
    check_eq("init_done seen", 128'(ok), 128'h1);
    check_eq("init log size", 128'(log_a.size() >= CFG_IDX + 1), 128'h1);
    check_eq("pwr write 6B<-00", 128'(log_a[0]), 128'h6B00);
`ifdef MPU_SCAN_WHOAMI_CHECK_EN
    check_eq("whoami read 75", 128'(log_a[1]), 128'hF500);
`endif
    check_eq("cfg write 37<-02", 128'(log_a[CFG_IDX]), 128'h3702);

    // First frame.
    wait_valid_a(400, ok);
    check_eq("frame1 valid seen", 128'(ok), 128'h1);
    cyc0 = cyc;
    check_eq("frame1 sample_data", 128'(sd_a), 128'(frame_exp));
    check_eq("frame1 frame_count", 128'(fc_a), 128'h1);
    check_eq("frame1 arm with valid", 128'(arm_a), 128'h1);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("scan addr %0d", i), 128'(log_a[CFG_IDX + 1 + i]), 128'(scan_exp[i]));
    @(negedge clk);
    check_eq("valid one cycle", 128'(sv_a), 128'h0);
    check_eq("arm held in idle", 128'(arm_a), 128'h1);

    // Second frame: period 6*7+1+10.
    wait_valid_a(200, ok);
    check_eq("frame2 valid seen", 128'(ok), 128'h1);
    check_eq("frame period", 128'(cyc - cyc0), 128'd53);
    check_eq("frame2 frame_count", 128'(fc_a), 128'h2);
    check_eq("frame2 sample_data", 128'(sd_a), 128'(frame_exp));

    // Wrap: frame_count forced to FFFF while idle.
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    wait_valid_a(200, ok);
    check_eq("wrap valid seen", 128'(ok), 128'h1);
    check_eq("wrap frame_count", 128'(fc_a), 128'h0);

    // Reset during byte 3 of a later frame.
    for (int n = 0; n < 10 && fc_a != 16'd4; n++) wait_valid_a(200, ok);
    check_eq("reach frame 4", 128'(fc_a), 128'h4);
    wait_starts_a(4, 200, ok);
    check_eq("mid-scan starts seen", 128'(ok), 128'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async reset");
    log_a.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init_a(200, ok);
    check_eq("restart init_done seen", 128'(ok), 128'h1);
    check_eq("restart pwr write", 128'(log_a[0]), 128'h6B00);
    check_eq("restart cfg write", 128'(log_a[CFG_IDX]), 128'h3702);
    wait_valid_a(400, ok);
    check_eq("restart valid seen", 128'(ok), 128'h1);
    check_eq("restart frame_count", 128'(fc_a), 128'h1);
    check_eq("restart sample_data", 128'(sd_a), 128'(frame_exp));
    check_eq("start while busy (default)", 128'(start_busy_a), 128'h0);

    // 7-channel, zero-idle instance.
    check_eq("dut7 frames seen", 128'(valid7 >= 2), 128'h1);
    check_eq("dut7 log size", 128'(log_7.size() >= CFG_IDX + 15), 128'h1);
    for (int i = 0; i < 14; i++)
      check_eq($sformatf("dut7 scan addr %0d", i), 128'(log_7[CFG_IDX + 1 + i]),
               128'(16'h8000 | ((16'h3B + 16'(i)) << 8)));
    check_eq("dut7 sample_data", 128'(data7),
             128'(112'h4748_4546_4344_4142_3F40_3D3E_3B3C));
    check_eq("dut7 arm pulses seen", 128'(arm7_pulses >= 2), 128'h1);
    check_eq("dut7 arm width not 1", 128'(arm7_bad), 128'h0);
    check_eq("start while busy (dut7)", 128'(start_busy_7), 128'h0);

`ifdef MPU_SCAN_WHOAMI_CHECK_EN
    check_eq("good whoami", 128'(who_a), 128'h71);
    check_eq("good id_error", 128'(iderr_a), 128'h0);
    check_eq("bad whoami", 128'(who_b), 128'h70);
    check_eq("bad id_error", 128'(iderr_b), 128'h1);
    check_eq("bad starts after err", 128'(starts_b), 128'h2);
    check_eq("bad sample_valid", 128'(valid_b), 128'h0);
    check_eq("bad arm_read_enable", 128'(arm_b_cnt), 128'h0);
    check_eq("bad init_done", 128'(init_b), 128'h0);
`else
    check_eq("whoami unused", 128'(who_a), 128'h0);
    check_eq("id_error unused", 128'(iderr_a), 128'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
